// File: rtl/mempipe_arb_if.sv
// Request/grant bundle between the loadq/storeq/fillq ports, the mempipe stall and the MM1 stage.
// The master side drives requests and the stall; the arbiter is the slave.
interface mempipe_arb_if #(
    parameter int PKT_W = 128
);
    logic             pipe_stall_mm0;
    logic             ld_req_mm0;
    logic [PKT_W-1:0] ld_req_pkt_mm0;
    logic             ld_gnt_mm0;
    logic             st_req_mm0;
    logic [PKT_W-1:0] st_req_pkt_mm0;
    logic             st_gnt_mm0;
    logic             fl_req_mm0;
    logic [PKT_W-1:0] fl_req_pkt_mm0;
    logic             fl_gnt_mm0;
    logic             req_valid_mm1;
    logic [PKT_W-1:0] req_pkt_mm1;
    logic [1:0]       req_src_mm1;

    modport master (
        output pipe_stall_mm0,
        output ld_req_mm0, ld_req_pkt_mm0,
        output st_req_mm0, st_req_pkt_mm0,
        output fl_req_mm0, fl_req_pkt_mm0,
        input  ld_gnt_mm0, st_gnt_mm0, fl_gnt_mm0,
        input  req_valid_mm1, req_pkt_mm1, req_src_mm1
    );

    modport slave (
        input  pipe_stall_mm0,
        input  ld_req_mm0, ld_req_pkt_mm0,
        input  st_req_mm0, st_req_pkt_mm0,
        input  fl_req_mm0, fl_req_pkt_mm0,
        output ld_gnt_mm0, st_gnt_mm0, fl_gnt_mm0,
        output req_valid_mm1, req_pkt_mm1, req_src_mm1
    );
endinterface

// File: rtl/mempipe_arb.sv
// MM0 arbiter for the shared L1 mempipe: fill priority with burst limit, ld/st round-robin
// with starvation promotion, and a one-cycle MM1 packet register.
module mempipe_arb #(
    parameter int PKT_W          = 128,
    parameter int STARVE_MAX     = 8,
    parameter int FILL_BURST_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    mempipe_arb_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(FILL_BURST_MAX + 1);
    localparam logic [SW-1:0] ST_MAX = SW'(STARVE_MAX);
    localparam logic [BW-1:0] FB_MAX = BW'(FILL_BURST_MAX);

    logic             gnt_ld, gnt_st, gnt_fl;
    logic             any_ldst;
    logic             fl_demote;
    logic             rr_q, rr_d;
    logic [SW-1:0]    ld_starve_q, ld_starve_d;
    logic [SW-1:0]    st_starve_q, st_starve_d;
    logic [BW-1:0]    fl_burst_q, fl_burst_d;
    logic             valid_q, valid_d;
    logic [1:0]       src_q, src_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;

    // Stalled cycles hold the count only while the requester keeps asking.
    function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cnt,
                                                  input logic req, input logic gnt,
                                                  input logic stall);
        if (!req || gnt) return '0;
        if (stall) return cnt;
        return (cnt == ST_MAX) ? cnt : cnt + 1'b1;
    endfunction

    assign any_ldst  = bus.ld_req_mm0 | bus.st_req_mm0;
    assign fl_demote = (fl_burst_q == FB_MAX);

    always_comb begin
        gnt_ld = 1'b0;
        gnt_st = 1'b0;
        gnt_fl = 1'b0;
        if (!reset && !bus.pipe_stall_mm0) begin
            if (st_starve_q == ST_MAX && bus.st_req_mm0)      gnt_st = 1'b1;
            else if (ld_starve_q == ST_MAX && bus.ld_req_mm0) gnt_ld = 1'b1;
            else if (bus.fl_req_mm0 && !fl_demote)            gnt_fl = 1'b1;
            else if (any_ldst) begin
                // rr_q=0 prefers ld, rr_q=1 prefers st; fall back to whichever is asking
                if (rr_q ? !bus.st_req_mm0 : bus.ld_req_mm0) gnt_ld = 1'b1;
                else                                         gnt_st = 1'b1;
            end
            else if (bus.fl_req_mm0)                          gnt_fl = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_ld)      rr_d = 1'b1;
        else if (gnt_st) rr_d = 1'b0;

        ld_starve_d = starve_next(ld_starve_q, bus.ld_req_mm0, gnt_ld, bus.pipe_stall_mm0);
        st_starve_d = starve_next(st_starve_q, bus.st_req_mm0, gnt_st, bus.pipe_stall_mm0);

        fl_burst_d = fl_burst_q;
        if (gnt_ld || gnt_st || !any_ldst)      fl_burst_d = '0;
        else if (gnt_fl && fl_burst_q != FB_MAX) fl_burst_d = fl_burst_q + 1'b1;

        valid_d = gnt_ld | gnt_st | gnt_fl;
        src_d   = 2'd0;
        pkt_d   = pkt_q;
        if (gnt_ld) begin
            src_d = 2'd1;
            pkt_d = bus.ld_req_pkt_mm0;
        end else if (gnt_st) begin
            src_d = 2'd2;
            pkt_d = bus.st_req_pkt_mm0;
        end else if (gnt_fl) begin
            src_d = 2'd3;
            pkt_d = bus.fl_req_pkt_mm0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= 1'b0;
            ld_starve_q <= '0;
            st_starve_q <= '0;
            fl_burst_q  <= '0;
            valid_q     <= 1'b0;
            src_q       <= 2'd0;
            pkt_q       <= '0;
        end else begin
            rr_q        <= rr_d;
            ld_starve_q <= ld_starve_d;
            st_starve_q <= st_starve_d;
            fl_burst_q  <= fl_burst_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
            pkt_q       <= pkt_d;
        end
    end

    assign bus.ld_gnt_mm0    = gnt_ld;
    assign bus.st_gnt_mm0    = gnt_st;
    assign bus.fl_gnt_mm0    = gnt_fl;
    assign bus.req_valid_mm1 = valid_q;
    assign bus.req_src_mm1   = src_q;
    assign bus.req_pkt_mm1   = pkt_q;
endmodule

// File: tb/tb_mempipe_arb.sv
// Directed bench for mempipe_arb: one instance with the default fill burst limit,
// a second with the burst limit raised to 16 for the fill-vs-store starvation case.
module tb_mempipe_arb;
    localparam int PKT_W = 128;
    localparam logic [2:0] G0 = 3'b000;
    localparam logic [2:0] GL = 3'b001;
    localparam logic [2:0] GS = 3'b010;
    localparam logic [2:0] GF = 3'b100;
    localparam logic [PKT_W-1:0] PKT_LD = 128'hA5;
    localparam logic [PKT_W-1:0] PKT_ST = 128'h5A5A_0000_1111_2222_3333_4444_5555_6622;
    localparam logic [PKT_W-1:0] PKT_FL = 128'hF00D_CAFE_0000_0000_0000_0000_BEEF_00C3;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mempipe_arb_if #(.PKT_W(PKT_W)) a ();
    mempipe_arb_if #(.PKT_W(PKT_W)) b ();

    mempipe_arb #(.PKT_W(PKT_W), .STARVE_MAX(8), .FILL_BURST_MAX(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    mempipe_arb #(.PKT_W(PKT_W), .STARVE_MAX(8), .FILL_BURST_MAX(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_src(input logic [2:0] g);
        case (g)
            GL:      return 2'd1;
            GS:      return 2'd2;
            GF:      return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [PKT_W-1:0] exp_pkt(input logic [2:0] g);
        case (g)
            GL:      return PKT_LD;
            GS:      return PKT_ST;
            default: return PKT_FL;
        endcase
    endfunction

    // Check this cycle's grant, advance one clock, then check the MM1 stage it produced.
    task automatic cyc(input bit use_b, input string tag, input logic [2:0] eg);
        logic [2:0] g;
        g = use_b ? {b.fl_gnt_mm0, b.st_gnt_mm0, b.ld_gnt_mm0}
                  : {a.fl_gnt_mm0, a.st_gnt_mm0, a.ld_gnt_mm0};
        chk({tag, "_gnt"}, PKT_W'(g), PKT_W'(eg));
        tick();
        chk({tag, "_valid"}, PKT_W'(use_b ? b.req_valid_mm1 : a.req_valid_mm1), PKT_W'(eg != G0));
        chk({tag, "_src"}, PKT_W'(use_b ? b.req_src_mm1 : a.req_src_mm1), PKT_W'(exp_src(eg)));
        if (eg != G0)
            chk({tag, "_pkt"}, use_b ? b.req_pkt_mm1 : a.req_pkt_mm1, exp_pkt(eg));
    endtask

    task automatic set_reqs(input bit ld, input bit st, input bit fl, input bit stall);
        a.ld_req_mm0 = ld;  a.st_req_mm0 = st;  a.fl_req_mm0 = fl;  a.pipe_stall_mm0 = stall;
    endtask

    task automatic do_reset();
        set_reqs(0, 0, 0, 0);
        b.ld_req_mm0 = 0;  b.st_req_mm0 = 0;  b.fl_req_mm0 = 0;  b.pipe_stall_mm0 = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [2:0] seq [10];
    logic [2:0] sseq [17];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a.ld_req_pkt_mm0 = PKT_LD;  a.st_req_pkt_mm0 = PKT_ST;  a.fl_req_pkt_mm0 = PKT_FL;
        b.ld_req_pkt_mm0 = PKT_LD;  b.st_req_pkt_mm0 = PKT_ST;  b.fl_req_pkt_mm0 = PKT_FL;
        b.ld_req_mm0 = 0;  b.st_req_mm0 = 0;  b.fl_req_mm0 = 0;  b.pipe_stall_mm0 = 0;

        // reset held two cycles with every request asserted
        reset = 1'b1;
        set_reqs(1, 1, 1, 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            cyc(0, "reset", G0);
        end
        do_reset();

        // single load
        set_reqs(1, 0, 0, 0);
        #1;
        cyc(0, "single_ld", GL);
        set_reqs(0, 0, 0, 0);
        #1;
        cyc(0, "idle", G0);

        // ld+st alternate starting from ld
        do_reset();
        set_reqs(1, 1, 0, 0);
        #1;
        cyc(0, "rr0", GL);
        cyc(0, "rr1", GS);
        cyc(0, "rr2", GL);
        cyc(0, "rr3", GS);

        // fill burst limited to 4 while a load waits
        do_reset();
        set_reqs(1, 0, 1, 0);
        seq = '{GF, GF, GF, GF, GL, GF, GF, GF, GF, GL};
        #1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, $sformatf("fl_burst%0d", i), seq[i]);
        end

        // stall in the middle of a fill burst: counters and burst must hold
        do_reset();
        set_reqs(1, 1, 1, 0);
        #1;
        cyc(0, "pre_stall0", GF);
        cyc(0, "pre_stall1", GF);
        a.pipe_stall_mm0 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, $sformatf("stall%0d", i), G0);
        end
        a.pipe_stall_mm0 = 1'b0;
        seq = '{GF, GF, GL, GF, GF, GF, GS, GF, G0, G0};
        #1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, $sformatf("post_stall%0d", i), seq[i]);
        end

        // reset mid-operation drops the MM1 packet
        do_reset();
        set_reqs(1, 0, 0, 0);
        #1;
        cyc(0, "pre_rst", GL);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", PKT_W'({a.fl_gnt_mm0, a.st_gnt_mm0, a.ld_gnt_mm0}), PKT_W'(G0));
        tick();
        chk("mid_rst_valid", PKT_W'(a.req_valid_mm1), PKT_W'(0));
        chk("mid_rst_src", PKT_W'(a.req_src_mm1), PKT_W'(0));
        chk("mid_rst_pkt", a.req_pkt_mm1, PKT_W'(0));
        reset = 1'b0;

        // burst limit 16: store starves for 8 fills, wins the 9th cycle, fill resumes
        do_reset();
        b.fl_req_mm0 = 1'b1;
        b.st_req_mm0 = 1'b1;
        for (int i = 0; i < 17; i++) sseq[i] = GF;
        sseq[8] = GS;
        #1;
        for (int i = 0; i < 10; i++) begin
            cyc(1, $sformatf("starve%0d", i), sseq[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
